// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with programmable limit, stop-or-wrap terminal
// handling and parallel load. All outputs registered.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | paused; max_reg tracks max_bcd every edge; run=1 starts
//   ST_COUNT | stepping every edge while run=1; max_reg frozen
//   ST_DONE  | stopped at terminal (wrap=0); done=1; run=0 or load exits
module bcd_counter_n #(
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  run,
  input  logic                  up_dn,
  input  logic                  wrap,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   max_bcd,
  output logic [4*DIGITS-1:0]   count,
  output logic                  done,
  output logic                  tc
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   count_q;
  logic [W-1:0]   max_reg_q;
  logic           done_q;
  logic           tc_q;

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] max_clamp;
  logic [W-1:0] load_clamp;
  logic [W-1:0] load_lim;
  logic [W-1:0] step_val;
  logic         at_term;
  logic         step_hits;

  // Counting up, anything at or above the limit (overrange) counts as terminal.
  always_comb begin
    max_clamp  = bcd_clamp(max_bcd);
    load_clamp = bcd_clamp(load_val);
    load_lim   = (load_clamp > max_clamp) ? max_clamp : load_clamp;
    step_val   = up_dn ? bcd_inc(count_q) : bcd_dec(count_q);
    at_term    = up_dn ? (count_q >= max_reg_q) : (count_q == '0);
    step_hits  = up_dn ? (step_val == max_reg_q) : (step_val == '0);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      max_reg_q <= {DIGITS{4'd9}};
      done_q    <= 1'b0;
      tc_q      <= 1'b0;
    end else if (load) begin
      state_q   <= ST_IDLE;
      count_q   <= load_lim;
      max_reg_q <= max_clamp;
      done_q    <= 1'b0;
      tc_q      <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COUNT: begin
          if (state_q == ST_IDLE) max_reg_q <= max_clamp;
          if (!run) begin
            state_q <= ST_IDLE;
          end else if (at_term) begin
            if (wrap) begin
              count_q <= up_dn ? '0 : max_reg_q;
              tc_q    <= 1'b1;
              state_q <= ST_COUNT;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            count_q <= step_val;
            if (step_hits && !wrap) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_COUNT;
            end
          end
        end
        ST_DONE: begin
          if (!run) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed bench for bcd_counter_n (DIGITS=2): one task per scenario with
// hand-computed expected count/done/tc after each rising edge.
module tb_bcd_counter_n;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       run, up_dn, wrap, load;
  logic [7:0] load_val, max_bcd, count;
  logic       done, tc;
  int         passed = 0;
  int         total  = 0;

  bcd_counter_n #(.DIGITS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .run(run), .up_dn(up_dn), .wrap(wrap),
    .load(load), .load_val(load_val), .max_bcd(max_bcd),
    .count(count), .done(done), .tc(tc)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] hi, lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load     = 1'b1;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; run = 1'b1; up_dn = 1'b1; wrap = 1'b0; load = 1'b0;
    load_val = 8'h00; max_bcd = 8'h50;
    tick();
    tick();
    total++;
    if (count !== 8'h00 || done !== 1'b0 || tc !== 1'b0)
      $display("FAIL reset: count=%h done=%b tc=%b, want 00 0 0", count, done, tc);
    else passed++;
  endtask

  task automatic test_up_stop();
    logic [7:0] ec;
    RST_N = 1'b1; run = 1'b0; max_bcd = 8'h50; up_dn = 1'b1; wrap = 1'b0;
    tick();
    run = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      ec = bcd2(i);
      total++;
      if (count !== ec || done !== (i == 50) || tc !== 1'b0)
        $display("FAIL up_stop[%0d]: count=%h done=%b tc=%b, want %h %b 0",
                 i, count, done, tc, ec, (i == 50));
      else passed++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count !== 8'h50 || done !== 1'b1)
        $display("FAIL up_stop_hold[%0d]: count=%h done=%b, want 50 1", i, count, done);
      else passed++;
    end
    run = 1'b0;
    tick();
    total++;
    if (count !== 8'h50 || done !== 1'b0)
      $display("FAIL up_stop_release: count=%h done=%b, want 50 0", count, done);
    else passed++;
  endtask

  task automatic test_up_wrap();
    logic [7:0] ec [4] = '{8'h11, 8'h12, 8'h00, 8'h01};
    logic       et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    run = 1'b0; max_bcd = 8'h12; up_dn = 1'b1; wrap = 1'b1;
    do_load(8'h10);
    total++;
    if (count !== 8'h10)
      $display("FAIL up_wrap_load: count=%h, want 10", count);
    else passed++;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (count !== ec[i] || done !== 1'b0 || tc !== et[i])
        $display("FAIL up_wrap[%0d]: count=%h done=%b tc=%b, want %h 0 %b",
                 i, count, done, tc, ec[i], et[i]);
      else passed++;
    end
    run = 1'b0;
    tick();
  endtask

  task automatic test_down();
    logic [7:0] ec [4] = '{8'h02, 8'h01, 8'h00, 8'h00};
    logic       ed [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    run = 1'b0; max_bcd = 8'h99;
    do_load(8'h00);
    up_dn = 1'b0; wrap = 1'b1; run = 1'b1;
    tick();
    total++;
    if (count !== 8'h99 || tc !== 1'b1 || done !== 1'b0)
      $display("FAIL down_wrap0: count=%h tc=%b done=%b, want 99 1 0", count, tc, done);
    else passed++;
    tick();
    total++;
    if (count !== 8'h98 || tc !== 1'b0)
      $display("FAIL down_wrap1: count=%h tc=%b, want 98 0", count, tc);
    else passed++;
    run = 1'b0;
    tick();
    do_load(8'h03);
    wrap = 1'b0; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (count !== ec[i] || done !== ed[i] || tc !== 1'b0)
        $display("FAIL down_stop[%0d]: count=%h done=%b tc=%b, want %h %b 0",
                 i, count, done, tc, ec[i], ed[i]);
      else passed++;
    end
    run = 1'b0;
    tick();
    total++;
    if (count !== 8'h00 || done !== 1'b0)
      $display("FAIL down_release: count=%h done=%b, want 00 0", count, done);
    else passed++;
  endtask

  task automatic test_load();
    run = 1'b0; up_dn = 1'b1; wrap = 1'b0; max_bcd = 8'h50;
    do_load(8'h20);
    run = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++;
      if (count !== bcd2(20 + i))
        $display("FAIL load_pre[%0d]: count=%h, want %h", i, count, bcd2(20 + i));
      else passed++;
    end
    do_load(8'h37);
    total++;
    if (count !== 8'h37 || done !== 1'b0 || tc !== 1'b0)
      $display("FAIL load_mid: count=%h done=%b tc=%b, want 37 0 0", count, done, tc);
    else passed++;
    tick();
    total++;
    if (count !== 8'h38)
      $display("FAIL load_resume: count=%h, want 38", count);
    else passed++;
    do_load(8'h7F);
    total++;
    if (count !== 8'h50 || done !== 1'b0)
      $display("FAIL load_limit: count=%h done=%b, want 50 0", count, done);
    else passed++;
    tick();
    total++;
    if (count !== 8'h50 || done !== 1'b1)
      $display("FAIL load_at_term: count=%h done=%b, want 50 1", count, done);
    else passed++;
    run = 1'b0;
    tick();
  endtask

  task automatic test_pause_max();
    logic [7:0] ec [3] = '{8'h17, 8'h18, 8'h19};
    run = 1'b0; up_dn = 1'b1; wrap = 1'b0; max_bcd = 8'h50;
    do_load(8'h10);
    run = 1'b1;
    repeat (5) tick();
    total++;
    if (count !== 8'h15)
      $display("FAIL pause_pre: count=%h, want 15", count);
    else passed++;
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (count !== 8'h15 || done !== 1'b0)
        $display("FAIL pause_hold[%0d]: count=%h done=%b, want 15 0", i, count, done);
      else passed++;
    end
    run = 1'b1;
    tick();
    max_bcd = 8'h17;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (count !== ec[i] || done !== 1'b0)
        $display("FAIL max_frozen[%0d]: count=%h done=%b, want %h 0", i, count, done, ec[i]);
      else passed++;
    end
    max_bcd = 8'hAB;
    run = 1'b0;
    tick();
    do_load(8'h97);
    total++;
    if (count !== 8'h97)
      $display("FAIL max_clamp_load: count=%h, want 97", count);
    else passed++;
    run = 1'b1;
    tick();
    tick();
    total++;
    if (count !== 8'h99 || done !== 1'b1)
      $display("FAIL max_clamp_term: count=%h done=%b, want 99 1", count, done);
    else passed++;
    run = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    run = 1'b0; up_dn = 1'b1; wrap = 1'b0; max_bcd = 8'h99;
    do_load(8'h40);
    run = 1'b1;
    tick();
    tick();
    total++;
    if (count !== 8'h42)
      $display("FAIL rst_mid_pre: count=%h, want 42", count);
    else passed++;
    RST_N = 1'b0;
    tick();
    total++;
    if (count !== 8'h00 || done !== 1'b0 || tc !== 1'b0)
      $display("FAIL rst_mid: count=%h done=%b tc=%b, want 00 0 0", count, done, tc);
    else passed++;
    RST_N = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++;
      if (count !== bcd2(i))
        $display("FAIL rst_resume[%0d]: count=%h, want %h", i, count, bcd2(i));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_up_stop();
    test_up_wrap();
    test_down();
    test_load();
    test_pause_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
